// File: rtl/matbi_watch_pkg.sv
// Shared types and constants for the watch display back end:
// converter states, segment patterns, digit positions and range limits.
package matbi_watch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } conv_state_e;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

  localparam int unsigned SEC_LIMIT  = 60;
  localparam int unsigned MIN_LIMIT  = 60;
  localparam int unsigned HOUR_LIMIT = 24;

  function automatic logic [5:0] digit_onehot(input logic [2:0] idx);
    return 6'b000001 << idx;
  endfunction

endpackage

// File: rtl/matbi_seg_decoder.sv
// Combinational BCD to 7-segment decoder; dash overrides blank, blank overrides digit.
module matbi_seg_decoder
  import matbi_watch_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/matbi_watch_display.sv
// Watch display back end: sequential binary-to-BCD converter with atomic digit
// update and range check, programmable digit scan and registered display outputs.
module matbi_watch_display
  import matbi_watch_pkg::*;
#(
  parameter int unsigned P_COUNT_BIT = 30,
  parameter int unsigned P_SEC_BIT   = 6,
  parameter int unsigned P_MIN_BIT   = 6,
  parameter int unsigned P_HOUR_BIT  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_en,
  input  logic [P_COUNT_BIT-1:0] i_scan_div,
  input  logic [P_SEC_BIT-1:0]   i_sec,
  input  logic [P_MIN_BIT-1:0]   i_min,
  input  logic [P_HOUR_BIT-1:0]  i_hour,
  output logic [5:0]             o_digit_sel,
  output logic [6:0]             o_seg,
  output logic                   o_dp,
  output logic                   o_upd,
  output logic                   o_err
);

  localparam logic [P_SEC_BIT-1:0]   SEC_TEN   = P_SEC_BIT'(10);
  localparam logic [P_MIN_BIT-1:0]   MIN_TEN   = P_MIN_BIT'(10);
  localparam logic [P_HOUR_BIT-1:0]  HOUR_TEN  = P_HOUR_BIT'(10);
  localparam logic [P_SEC_BIT-1:0]   SEC_LIM   = P_SEC_BIT'(SEC_LIMIT);
  localparam logic [P_MIN_BIT-1:0]   MIN_LIM   = P_MIN_BIT'(MIN_LIMIT);
  localparam logic [P_HOUR_BIT-1:0]  HOUR_LIM  = P_HOUR_BIT'(HOUR_LIMIT);
  localparam logic [P_COUNT_BIT-1:0] CNT_ONE   = P_COUNT_BIT'(1);

  conv_state_e state_q, state_d;

  logic                  pend_q, pend_d;
  logic [P_SEC_BIT-1:0]  snap_sec_q, snap_sec_d;
  logic [P_MIN_BIT-1:0]  snap_min_q, snap_min_d;
  logic [P_HOUR_BIT-1:0] snap_hour_q, snap_hour_d;
  logic [P_SEC_BIT-1:0]  sec_w_q, sec_w_d;
  logic [P_MIN_BIT-1:0]  min_w_q, min_w_d;
  logic [P_HOUR_BIT-1:0] hour_w_q, hour_w_d;
  logic [3:0]            sec_t_q, sec_t_d;
  logic [3:0]            min_t_q, min_t_d;
  logic [3:0]            hour_t_q, hour_t_d;
  logic [5:0][3:0]       bcd_q, bcd_d;
  logic                  err_q, err_d;
  logic                  upd_q, upd_d;

  logic [P_COUNT_BIT-1:0] cnt_q, cnt_d;
  logic [P_COUNT_BIT-1:0] div_eff;
  logic                   term;
  logic [2:0]             idx_q, idx_d;
  logic [5:0]             sel_q, sel_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [3:0]             sel_bcd;
  logic [6:0]             dec_seg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    snap_sec_d  = snap_sec_q;
    snap_min_d  = snap_min_q;
    snap_hour_d = snap_hour_q;
    sec_w_d     = sec_w_q;
    min_w_d     = min_w_q;
    hour_w_d    = hour_w_q;
    sec_t_d     = sec_t_q;
    min_t_d     = min_t_q;
    hour_t_d    = hour_t_q;
    bcd_d       = bcd_q;
    err_d       = err_q;
    upd_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q || ({i_hour, i_min, i_sec} != {snap_hour_q, snap_min_q, snap_sec_q})) begin
          pend_d      = 1'b0;
          snap_sec_d  = i_sec;
          snap_min_d  = i_min;
          snap_hour_d = i_hour;
          sec_w_d     = i_sec;
          min_w_d     = i_min;
          hour_w_d    = i_hour;
          sec_t_d     = '0;
          min_t_d     = '0;
          hour_t_d    = '0;
          state_d     = S_CONV;
        end
      end
      S_CONV: begin
        if (sec_w_q >= SEC_TEN) begin
          sec_w_d = sec_w_q - SEC_TEN;
          sec_t_d = sec_t_q + 4'd1;
        end
        if (min_w_q >= MIN_TEN) begin
          min_w_d = min_w_q - MIN_TEN;
          min_t_d = min_t_q + 4'd1;
        end
        if (hour_w_q >= HOUR_TEN) begin
          hour_w_d = hour_w_q - HOUR_TEN;
          hour_t_d = hour_t_q + 4'd1;
        end
        if ((sec_w_q < SEC_TEN) && (min_w_q < MIN_TEN) && (hour_w_q < HOUR_TEN)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d[DIG_SEC_ONES]  = sec_w_q[3:0];
        bcd_d[DIG_SEC_TENS]  = sec_t_q;
        bcd_d[DIG_MIN_ONES]  = min_w_q[3:0];
        bcd_d[DIG_MIN_TENS]  = min_t_q;
        bcd_d[DIG_HOUR_ONES] = hour_w_q[3:0];
        bcd_d[DIG_HOUR_TENS] = hour_t_q;
        err_d   = (snap_sec_q >= SEC_LIM) || (snap_min_q >= MIN_LIM) || (snap_hour_q >= HOUR_LIM);
        upd_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan divider: a counter left above a shrunken divisor runs on and wraps naturally.
  always_comb begin
    div_eff = (i_scan_div == '0) ? CNT_ONE : i_scan_div;
    term    = (cnt_q == (div_eff - CNT_ONE));
    cnt_d   = term ? '0 : (cnt_q + CNT_ONE);
    idx_d   = idx_q;
    if (term) begin
      idx_d = (idx_q == DIG_HOUR_TENS) ? DIG_SEC_ONES : (idx_q + 3'd1);
    end
  end

  // Outputs decode from next-state BCD so new digits show in the same cycle as o_upd.
  assign sel_bcd = bcd_d[idx_q];

  matbi_seg_decoder u_seg_decoder (
    .bcd_i   (sel_bcd),
    .blank_i ((idx_q == DIG_HOUR_TENS) && (sel_bcd == 4'd0)),
    .dash_i  (err_d),
    .seg_o   (dec_seg)
  );

  always_comb begin
    sel_d = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (i_en) begin
      sel_d = digit_onehot(idx_q);
      seg_d = dec_seg;
      dp_d  = !err_d && ((idx_q == DIG_MIN_ONES) || (idx_q == DIG_HOUR_ONES));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q      <= 1'b1;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hour_q <= '0;
      sec_w_q     <= '0;
      min_w_q     <= '0;
      hour_w_q    <= '0;
      sec_t_q     <= '0;
      min_t_q     <= '0;
      hour_t_q    <= '0;
      bcd_q       <= '0;
      err_q       <= 1'b0;
      upd_q       <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= DIG_SEC_ONES;
      sel_q       <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      snap_sec_q  <= snap_sec_d;
      snap_min_q  <= snap_min_d;
      snap_hour_q <= snap_hour_d;
      sec_w_q     <= sec_w_d;
      min_w_q     <= min_w_d;
      hour_w_q    <= hour_w_d;
      sec_t_q     <= sec_t_d;
      min_t_q     <= min_t_d;
      hour_t_q    <= hour_t_d;
      bcd_q       <= bcd_d;
      err_q       <= err_d;
      upd_q       <= upd_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign o_digit_sel = sel_q;
  assign o_seg       = seg_q;
  assign o_dp        = dp_q;
  assign o_upd       = upd_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_matbi_watch_display.sv
// Self-checking bench for matbi_watch_display: latency scoreboard plus per-scenario checks.
module tb_matbi_watch_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_en;
  logic [29:0] i_scan_div;
  logic [5:0]  i_sec;
  logic [5:0]  i_min;
  logic [4:0]  i_hour;
  logic [5:0]  o_digit_sel;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_upd;
  logic        o_err;

  always #5 clk = ~clk;

  matbi_watch_display #(
    .P_COUNT_BIT (30),
    .P_SEC_BIT   (6),
    .P_MIN_BIT   (6),
    .P_HOUR_BIT  (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_en        (i_en),
    .i_scan_div  (i_scan_div),
    .i_sec       (i_sec),
    .i_min       (i_min),
    .i_hour      (i_hour),
    .o_digit_sel (o_digit_sel),
    .o_seg       (o_seg),
    .o_dp        (o_dp),
    .o_upd       (o_upd),
    .o_err       (o_err)
  );

  typedef struct {
    int s;
    int m;
    int h;
    int due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  logic [6:0]  seg_tab[10];

  int cur_s = 0, cur_m = 0, cur_h = 0;
  bit cur_err = 1'b0;
  bit en_q = 1'b0, out_valid = 1'b0;
  int m_busy = 0;
  bit m_pend = 1'b1;
  int snap_s = 0, snap_m = 0, snap_h = 0;

  function automatic bit range_err(input int s, input int m, input int h);
    return (s >= 60) || (m >= 60) || (h >= 24);
  endfunction

  function automatic int tens_max(input int s, input int m, input int h);
    int t;
    t = s / 10;
    if (m / 10 > t) t = m / 10;
    if (h / 10 > t) t = h / 10;
    return t;
  endfunction

  function automatic int digit_val(input int k);
    case (k)
      0:       return cur_s % 10;
      1:       return cur_s / 10;
      2:       return cur_m % 10;
      3:       return cur_m / 10;
      4:       return cur_h % 10;
      default: return cur_h / 10;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int k);
    if (cur_err) return 7'h40;
    if (k == 5 && digit_val(5) == 0) return 7'h00;
    return seg_tab[digit_val(k)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: predicts which input snapshot is captured and when o_upd is due.
  initial begin
    int t;
    forever begin
      @(posedge clk);
      cyc++;
      en_q      = i_en;
      out_valid = reset;
      if (!reset) begin
        exp_q.delete();
        m_busy = 0;
        m_pend = 1'b1;
        snap_s = 0; snap_m = 0; snap_h = 0;
      end else if (m_busy != 0) begin
        m_busy--;
      end else if (m_pend || int'(i_sec) != snap_s || int'(i_min) != snap_m || int'(i_hour) != snap_h) begin
        m_pend = 1'b0;
        snap_s = int'(i_sec); snap_m = int'(i_min); snap_h = int'(i_hour);
        t = tens_max(snap_s, snap_m, snap_h);
        m_busy = t + 2;
        exp_q.push_back('{snap_s, snap_m, snap_h, cyc + t + 2});
      end
    end
  end

  // Scoreboard consumer and per-cycle display check.
  initial begin
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur_s = 0; cur_m = 0; cur_h = 0; cur_err = 1'b0;
      end else begin
        if (o_upd === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL upd_unexpected: o_upd=1 at cycle %0d, required no update", cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.due != cyc) begin
              n_bad++;
              $display("FAIL upd_latency: o_upd at cycle %0d, required cycle %0d", cyc, e.due);
            end
            cur_s = e.s; cur_m = e.m; cur_h = e.h;
            cur_err = range_err(e.s, e.m, e.h);
            n_cmp++;
            if (o_err !== cur_err) begin
              n_bad++;
              $display("FAIL err_flag: o_err=%b, required %b", o_err, cur_err);
            end
          end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
          n_cmp++;
          n_bad++;
          $display("FAIL upd_missing: no o_upd by cycle %0d, required at cycle %0d", cyc, exp_q[0].due);
          e = exp_q.pop_front();
          cur_s = e.s; cur_m = e.m; cur_h = e.h;
          cur_err = range_err(e.s, e.m, e.h);
        end
        n_cmp++;
        if (out_valid && en_q) begin
          k = -1;
          for (int i = 0; i < 6; i++) if (o_digit_sel === (6'b000001 << i)) k = i;
          if (k < 0) begin
            n_bad++;
            $display("FAIL digit_sel_onehot: o_digit_sel=%b, required one-hot", o_digit_sel);
          end else if (o_seg !== exp_seg(k) || o_dp !== (!cur_err && (k == 2 || k == 4))) begin
            n_bad++;
            $display("FAIL display_digit%0d: seg=%h dp=%b, required seg=%h dp=%b",
                     k, o_seg, o_dp, exp_seg(k), (!cur_err && (k == 2 || k == 4)));
          end
        end else if (o_digit_sel !== 6'd0 || o_seg !== 7'd0 || o_dp !== 1'b0) begin
          n_bad++;
          $display("FAIL display_off: sel=%b seg=%h dp=%b, required all 0", o_digit_sel, o_seg, o_dp);
        end
      end
    end
  end

  task automatic test_reset();
    bit seen = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({o_digit_sel, o_seg, o_dp, o_upd, o_err} !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: %h, required 0", {o_digit_sel, o_seg, o_dp, o_upd, o_err});
    end
    reset   = 1'b1;
    rel_cyc = cyc;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (o_upd === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || cyc - rel_cyc != 3) begin
      n_bad++;
      $display("FAIL reset_upd_latency: seen=%b after %0d cycles, required 3", seen, cyc - rel_cyc);
    end
  endtask

  task automatic test_scan();
    int j;
    logic [5:0] exp_sel;
    while (cyc - rel_cyc < 28) begin
      tick();
      j = cyc - rel_cyc;
      exp_sel = 6'b000001 << (((j - 1) / 4) % 6);
      n_cmp++;
      if (o_digit_sel !== exp_sel) begin
        n_bad++;
        $display("FAIL scan_sel_j%0d: sel=%b, required %b", j, o_digit_sel, exp_sel);
      end
      if (j == 4 || j == 21) begin
        n_cmp++;
        if (o_seg !== ((j == 4) ? 7'h3F : 7'h00)) begin
          n_bad++;
          $display("FAIL scan_seg_j%0d: seg=%h, required %h", j, o_seg, (j == 4) ? 7'h3F : 7'h00);
        end
      end
    end
  endtask

  task automatic test_step();
    int  n, k;
    bit  seen = 1'b0;
    int  dig[6] = '{9, 5, 9, 5, 3, 2};
    i_hour = 5'd12; i_min = 6'd34; i_sec = 6'd56;
    repeat (12) tick();
    i_hour = 5'd23; i_min = 6'd59; i_sec = 6'd59;
    n = cyc;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (o_upd === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || cyc - n != 8) begin
      n_bad++;
      $display("FAIL step_latency: seen=%b after %0d cycles, required 8", seen, cyc - n);
    end
    repeat (24) begin
      tick();
      k = ((cyc - rel_cyc - 1) / 4) % 6;
      n_cmp++;
      if (o_seg !== seg_tab[dig[k]] || o_dp !== (k == 2 || k == 4)) begin
        n_bad++;
        $display("FAIL step_digit%0d: seg=%h dp=%b, required seg=%h dp=%b",
                 k, o_seg, o_dp, seg_tab[dig[k]], (k == 2 || k == 4));
      end
    end
  endtask

  task automatic test_back_to_back();
    int fs, fm, fh;
    for (int i = 0; i < 20; i++) begin
      fs = int'($urandom_range(0, 59));
      fm = int'($urandom_range(0, 59));
      fh = int'($urandom_range(0, 23));
      i_sec = 6'(fs); i_min = 6'(fm); i_hour = 5'(fh);
      tick();
    end
    repeat (30) tick();
    n_cmp++;
    if (exp_q.size() != 0 || cur_s != fs || cur_m != fm || cur_h != fh) begin
      n_bad++;
      $display("FAIL burst_final: shown %0d:%0d:%0d pending=%0d, required %0d:%0d:%0d pending=0",
               cur_h, cur_m, cur_s, exp_q.size(), fh, fm, fs);
    end
  endtask

  task automatic test_range();
    bit seen = 1'b0;
    i_hour = 5'd25; i_min = 6'd60; i_sec = 6'd10;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (o_upd === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || o_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_err_set: seen=%b o_err=%b, required 1", seen, o_err);
    end
    repeat (24) begin
      tick();
      n_cmp++;
      if (o_seg !== 7'h40 || o_dp !== 1'b0) begin
        n_bad++;
        $display("FAIL range_dash: seg=%h dp=%b, required seg=40 dp=0", o_seg, o_dp);
      end
    end
    i_hour = 5'd1; i_min = 6'd2; i_sec = 6'd3;
    tick();
    n_cmp++;
    if (o_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_err_hold: o_err=%b, required 1", o_err);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (o_upd === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL range_err_clear: seen=%b o_err=%b, required 0", seen, o_err);
    end
  endtask

  task automatic test_enable();
    bit seen = 1'b0;
    i_en = 1'b0;
    repeat (2) tick();
    i_hour = 5'd7; i_min = 6'd8; i_sec = 6'd9;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_upd === 1'b1) seen = 1'b1;
      n_cmp++;
      if (o_digit_sel !== 6'd0 || o_seg !== 7'd0 || o_dp !== 1'b0) begin
        n_bad++;
        $display("FAIL enable_off: sel=%b seg=%h dp=%b, required 0", o_digit_sel, o_seg, o_dp);
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL enable_conv: o_upd seen=%b while disabled, required 1", seen);
    end
    i_en = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (!$onehot(o_digit_sel)) begin
      n_bad++;
      $display("FAIL enable_on: sel=%b, required one-hot", o_digit_sel);
    end
  endtask

  task automatic test_div01();
    int r;
    logic [5:0] exp_sel;
    for (int d = 0; d < 2; d++) begin
      reset = 1'b0;
      i_scan_div = 30'(d);
      repeat (2) tick();
      reset = 1'b1;
      r = cyc;
      repeat (12) begin
        tick();
        exp_sel = 6'b000001 << ((cyc - r - 1) % 6);
        n_cmp++;
        if (o_digit_sel !== exp_sel) begin
          n_bad++;
          $display("FAIL div%0d_sel: sel=%b, required %b", d, o_digit_sel, exp_sel);
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    int r;
    bit seen = 1'b0;
    i_hour = 5'd23; i_min = 6'd59; i_sec = 6'd59;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({o_digit_sel, o_seg, o_dp, o_upd, o_err} !== 16'd0) begin
      n_bad++;
      $display("FAIL async_reset: %h, required 0", {o_digit_sel, o_seg, o_dp, o_upd, o_err});
    end
    repeat (2) tick();
    reset = 1'b1;
    r = cyc;
    for (int i = 0; i < 15 && !seen; i++) begin
      tick();
      if (o_upd === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || cyc - r != 8) begin
      n_bad++;
      $display("FAIL reset_reconv_latency: seen=%b after %0d cycles, required 8", seen, cyc - r);
    end
    repeat (12) tick();
    n_cmp++;
    if (cur_h != 23 || cur_m != 59 || cur_s != 59) begin
      n_bad++;
      $display("FAIL reset_reconv_value: %0d:%0d:%0d, required 23:59:59", cur_h, cur_m, cur_s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
    reset = 1'b0;
    i_en = 1'b1;
    i_scan_div = 30'd4;
    i_sec = '0; i_min = '0; i_hour = '0;
    test_reset();
    test_scan();
    test_step();
    test_back_to_back();
    test_range();
    test_enable();
    test_div01();
    test_reset_mid_conv();
    repeat (2) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d updates outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
